// File: rtl/register_pipe.sv
// register_pipe: DEPTH chained two-entry skid stages with registered ready on every link.
// Define REGISTER_PIPE_COUNT_EN to add the registered occupancy output.
module register_pipe #(
  parameter int                    WORD_WIDTH  = 8,
  parameter int                    DEPTH       = 2,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_WIDTH-1:0] m_data
`ifdef REGISTER_PIPE_COUNT_EN
  ,
  output logic [((DEPTH == 0) ? 1 : $clog2(2 * DEPTH + 1))-1:0] occupancy
`endif
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign s_ready = m_ready;
      assign m_valid = s_valid;
      assign m_data  = s_data;
    end else begin : g_pipe
      // Link k feeds stage k; link DEPTH is the pipe output.
      logic [DEPTH:0]          link_valid;
      logic [DEPTH:0]          link_ready;
      logic [WORD_WIDTH-1:0]   link_data [DEPTH+1];

      assign link_valid[0]     = s_valid;
      assign link_data[0]      = s_data;
      assign link_ready[DEPTH] = m_ready;
      assign s_ready           = link_ready[0];
      assign m_valid           = link_valid[DEPTH];
      assign m_data            = link_data[DEPTH];

      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic                  valid_m;
        logic                  valid_s;
        logic [WORD_WIDTH-1:0] data_m;
        logic [WORD_WIDTH-1:0] data_s;
        logic                  in_xfer;
        logic                  out_xfer;

        assign in_xfer  = link_valid[k] & ~valid_s;
        assign out_xfer = valid_m & link_ready[k+1];

        // Skid always drains into main first so order is kept.
        always_ff @(posedge clock or negedge resetn) begin
          if (!resetn) begin
            valid_m <= 1'b0;
            valid_s <= 1'b0;
            data_m  <= RESET_VALUE;
            data_s  <= RESET_VALUE;
          end else if (clear) begin
            valid_m <= 1'b0;
            valid_s <= 1'b0;
            data_m  <= RESET_VALUE;
            data_s  <= RESET_VALUE;
          end else if (!valid_m || out_xfer) begin
            if (valid_s) begin
              valid_m <= 1'b1;
              data_m  <= data_s;
              valid_s <= in_xfer;
              if (in_xfer) begin
                data_s <= link_data[k];
              end
            end else begin
              valid_m <= in_xfer;
              if (in_xfer) begin
                data_m <= link_data[k];
              end
            end
          end else if (in_xfer) begin
            valid_s <= 1'b1;
            data_s  <= link_data[k];
          end
        end

        assign link_valid[k+1] = valid_m;
        assign link_data[k+1]  = data_m;
        assign link_ready[k]   = ~valid_s;
      end
    end
  endgenerate

`ifdef REGISTER_PIPE_COUNT_EN
  localparam int OCC_W = (DEPTH == 0) ? 1 : $clog2(2 * DEPTH + 1);

  logic count_up;
  logic count_down;

  assign count_up   = s_valid & s_ready;
  assign count_down = m_valid & m_ready;

  // Simultaneous accept and deliver leave the count unchanged.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      occupancy <= '0;
    end else if (clear) begin
      occupancy <= '0;
    end else if (count_up && !count_down) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (!count_up && count_down) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_register_pipe.sv
// tb_register_pipe: scoreboard bench for register_pipe at DEPTH 2 (RESET_VALUE 0x5A), DEPTH 3 (16-bit) and DEPTH 0.
// Occupancy is checked against the scoreboard depth when REGISTER_PIPE_COUNT_EN is defined.
module tb_register_pipe;

  logic clock = 1'b0;
  logic resetn;
  logic clear;

  always #5 clock = ~clock;

  logic       a_s_valid, a_s_ready, a_m_valid, a_m_ready;
  logic [7:0] a_s_data, a_m_data;
  logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready;
  logic [15:0] b_s_data, b_m_data;
  logic       z_s_valid, z_s_ready, z_m_valid, z_m_ready;
  logic [7:0] z_s_data, z_m_data;
`ifdef REGISTER_PIPE_COUNT_EN
  logic [2:0] a_occupancy;
  logic [2:0] b_occupancy;
  logic [0:0] z_occupancy;
`endif

  register_pipe #(.WORD_WIDTH(8), .DEPTH(2), .RESET_VALUE(8'h5A)) dut_a (
    .clock(clock), .resetn(resetn), .clear(clear),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data)
`ifdef REGISTER_PIPE_COUNT_EN
    , .occupancy(a_occupancy)
`endif
  );

  register_pipe #(.WORD_WIDTH(16), .DEPTH(3), .RESET_VALUE(16'h0000)) dut_b (
    .clock(clock), .resetn(resetn), .clear(clear),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data)
`ifdef REGISTER_PIPE_COUNT_EN
    , .occupancy(b_occupancy)
`endif
  );

  register_pipe #(.WORD_WIDTH(8), .DEPTH(0), .RESET_VALUE(8'h00)) dut_z (
    .clock(clock), .resetn(resetn), .clear(clear),
    .s_valid(z_s_valid), .s_ready(z_s_ready), .s_data(z_s_data),
    .m_valid(z_m_valid), .m_ready(z_m_ready), .m_data(z_m_data)
`ifdef REGISTER_PIPE_COUNT_EN
    , .occupancy(z_occupancy)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0]  qa[$];
  logic [15:0] qb[$];
  int a_pops = 0;
  int a_first_pop_cyc = 0;
  int a_last_pop_cyc = 0;
  logic a_hold = 1'b0;
  logic [7:0] a_held = '0;
  logic b_hold = 1'b0;
  logic [15:0] b_held = '0;

  always @(posedge clock) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [7:0] sd, input logic mr, input logic cl);
    @(posedge clock);
    #1;
    a_s_valid = sv;
    a_s_data  = sd;
    a_m_ready = mr;
    clear     = cl;
    @(negedge clock);
  endtask

  task automatic drainA(input int bound);
    int n;
    n = 0;
    while (qa.size() != 0 && n < bound) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    checkOutput("a_drain", 32'(qa.size()), 32'd0);
  endtask

  // Pipe A monitor: order, hold stability and occupancy against the scoreboard.
  always @(negedge clock) begin
    if (!resetn) begin
      a_hold = 1'b0;
    end else begin
`ifdef REGISTER_PIPE_COUNT_EN
      checkOutput("a_occupancy", 32'(a_occupancy), 32'(qa.size()));
`endif
      if (a_hold) begin
        checkOutput("a_hold_valid", 32'(a_m_valid), 32'd1);
        checkOutput("a_hold_data", 32'(a_m_data), 32'(a_held));
      end
      if (a_m_valid && a_m_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL a_extra_word: got 0x%0h, expected no word", a_m_data);
        end else begin
          checkOutput("a_order", 32'(a_m_data), 32'(qa.pop_front()));
        end
        if (a_pops == 0) a_first_pop_cyc = cyc;
        a_last_pop_cyc = cyc;
        a_pops++;
      end
      if (a_s_valid && a_s_ready && !clear) qa.push_back(a_s_data);
      a_hold = a_m_valid && !a_m_ready && !clear;
      a_held = a_m_data;
    end
  end

  // Pipe B monitor for the random run.
  always @(negedge clock) begin
    if (!resetn) begin
      b_hold = 1'b0;
    end else begin
`ifdef REGISTER_PIPE_COUNT_EN
      checkOutput("b_occupancy", 32'(b_occupancy), 32'(qb.size()));
`endif
      if (b_hold) begin
        checkOutput("b_hold_valid", 32'(b_m_valid), 32'd1);
        checkOutput("b_hold_data", 32'(b_m_data), 32'(b_held));
      end
      if (b_m_valid && b_m_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL b_extra_word: got 0x%0h, expected no word", b_m_data);
        end else begin
          checkOutput("b_order", 32'(b_m_data), 32'(qb.pop_front()));
        end
      end
      if (b_s_valid && b_s_ready && !clear) qb.push_back(b_s_data);
      b_hold = b_m_valid && !b_m_ready && !clear;
      b_held = b_m_data;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       sready_all;
    int         acc_cyc;
    int         n;
    int         first_ready;
    int         seen;
    int         fill;
    logic       zv [4];
    logic [7:0] zd [4];
    logic       zr [4];

    resetn = 1'b0; clear = 1'b0;
    a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
    z_s_valid = 1'b0; z_s_data = '0; z_m_ready = 1'b0;

    #12;
    checkOutput("reset_a_m_valid", 32'(a_m_valid), 32'd0);
    checkOutput("reset_a_m_data", 32'(a_m_data), 32'h5A);
    checkOutput("reset_a_s_ready", 32'(a_s_ready), 32'd1);
    checkOutput("reset_b_m_valid", 32'(b_m_valid), 32'd0);
    checkOutput("reset_b_s_ready", 32'(b_s_ready), 32'd1);
`ifdef REGISTER_PIPE_COUNT_EN
    checkOutput("reset_a_occupancy", 32'(a_occupancy), 32'd0);
`endif
    #10;
    resetn = 1'b1;

    // Streaming 0x01..0x10 with the sink always ready.
    sready_all = 1'b1;
    acc_cyc = 0;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
      if (!a_s_ready) sready_all = 1'b0;
      if (i == 1) acc_cyc = cyc;
    end
    drainA(20);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_s_ready_high", 32'(sready_all), 32'd1);
    checkOutput("stream_latency", 32'(a_first_pop_cyc - acc_cyc), 32'd2);
    checkOutput("stream_no_gaps", 32'(a_last_pop_cyc - a_first_pop_cyc), 32'd15);
    checkOutput("stream_count", 32'(a_pops), 32'd16);
    checkOutput("idle_m_valid", 32'(a_m_valid), 32'd0);
    checkOutput("idle_data_held", 32'(a_m_data), 32'h10);

    // Full backpressure: exactly four words fit, then release.
    n = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(n), 1'b0, 1'b0);
      if (a_s_ready) n++;
    end
    checkOutput("bp_accepted", 32'(n), 32'd4);
    checkOutput("bp_s_ready_low", 32'(a_s_ready), 32'd0);
`ifdef REGISTER_PIPE_COUNT_EN
    checkOutput("bp_occupancy", 32'(a_occupancy), 32'd4);
`endif
    first_ready = -1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(logic'(n < 8), 8'hA0 + 8'(n), 1'b1, 1'b0);
      if (a_s_ready && first_ready < 0) first_ready = i;
      if (a_s_ready && n < 8) n++;
    end
    checkOutput("bp_ready_recovery", 32'(first_ready >= 1 && first_ready <= 2), 32'd1);
    checkOutput("bp_total_sent", 32'(n), 32'd8);
    drainA(20);

    // Asynchronous reset between edges with three words inside.
    applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    checkOutput("async_m_valid", 32'(a_m_valid), 32'd0);
    checkOutput("async_m_data", 32'(a_m_data), 32'h5A);
    checkOutput("async_s_ready", 32'(a_s_ready), 32'd1);
    qa.delete();
    qb.delete();
    @(negedge clock);
    #1;
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      if (a_m_valid) seen++;
    end
    checkOutput("async_no_old_words", 32'(seen), 32'd0);

    // Clear with a concurrent 0x77, first on a full pipe, then with one word held.
    for (int f = 0; f < 2; f++) begin
      fill = (f == 0) ? 4 : 1;
      for (int i = 0; i < fill; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
      @(posedge clock);
      #1;
      qa.delete();
      clear = 1'b0;
      a_s_valid = 1'b0;
      @(negedge clock);
      checkOutput("clear_m_valid", 32'(a_m_valid), 32'd0);
      checkOutput("clear_m_data", 32'(a_m_data), 32'h5A);
      checkOutput("clear_s_ready", 32'(a_s_ready), 32'd1);
`ifdef REGISTER_PIPE_COUNT_EN
      checkOutput("clear_occupancy", 32'(a_occupancy), 32'd0);
`endif
      seen = 0;
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        if (a_m_valid) seen++;
      end
      checkOutput("clear_nothing_emerges", 32'(seen), 32'd0);
    end
    applyStimulus(1'b1, 8'h78, 1'b1, 1'b0);
    drainA(20);

    // DEPTH 0 pass-through: outputs follow inputs in the same cycle.
    zv[0] = 1'b1; zd[0] = 8'h3C; zr[0] = 1'b0;
    zv[1] = 1'b0; zd[1] = 8'hC3; zr[1] = 1'b1;
    zv[2] = 1'b1; zd[2] = 8'hFF; zr[2] = 1'b1;
    zv[3] = 1'b0; zd[3] = 8'h00; zr[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      z_s_valid = zv[i];
      z_s_data  = zd[i];
      z_m_ready = zr[i];
      #1;
      checkOutput("wire_s_ready", 32'(z_s_ready), 32'(zr[i]));
      checkOutput("wire_m_valid", 32'(z_m_valid), 32'(zv[i]));
      checkOutput("wire_m_data", 32'(z_m_data), 32'(zd[i]));
    end

    // Random valid/ready on the 16-bit DEPTH 3 pipe.
    for (int i = 0; i < 10000; i++) begin
      @(posedge clock);
      #1;
      b_s_valid = 1'($urandom_range(0, 1));
      b_s_data  = 16'($urandom);
      b_m_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clock);
    #1;
    b_s_valid = 1'b0;
    b_m_ready = 1'b1;
    n = 0;
    while (qb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    checkOutput("b_drain", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
